hex_word_fetcher: RTL

HEX_WORD_FETCHER -- requirements
Module: hex_word_fetcher

---
 rtl/hex_word_fetcher.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hex_word_fetcher.sv
// Prefetches one memory word per hex-display slot ahead of the beam and swaps it into word_value.
// Optional miss counter: define HEX_FETCH_MISS_CNT_EN to add the miss_count port.
module hex_word_fetcher #(
  parameter int unsigned DATA_WIDTH          = 16,
  parameter int unsigned ADDR_WIDTH          = 8,
  parameter int unsigned HEX_START_X         = 64,
  parameter int unsigned HEX_PIXELS_PER_WORD = 40,
  parameter int unsigned HEX_WORDS_PER_LINE  = 8,
  parameter int unsigned LINE_HEIGHT         = 16,
  parameter int unsigned HEX_LINES           = 24,
  parameter int unsigned BASE_ADDR           = 0,
  parameter int unsigned H_VISIBLE           = 640,
  parameter int unsigned V_TOTAL             = 525
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_ack,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] word_value,
  output logic                  fetch_miss
`ifdef HEX_FETCH_MISS_CNT_EN
  ,
  output logic [15:0]           miss_count
`endif
);

  localparam int unsigned HexRows = HEX_LINES * LINE_HEIGHT;
  localparam int unsigned SlotW   = $clog2(HEX_WORDS_PER_LINE + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StReady = 2'd2;

  logic [1:0]            state_q;
  logic [DATA_WIDTH-1:0] next_buf_q;
  logic [SlotW-1:0]      slot_q;
  // active_q: slot 0 was fetched for the upcoming row, so swaps are armed
  logic                  active_q;
  logic                  pending_q;

  logic [9:0]  next_row;
  logic [31:0] swap_x;
  logic        swap;
  logic        row0_trig;
  logic        line_trig;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [9:0]       row,
                                                      input logic [SlotW-1:0] slot);
    return ADDR_WIDTH'(BASE_ADDR + (32'(row) / LINE_HEIGHT) * HEX_WORDS_PER_LINE + 32'(slot));
  endfunction

  always_comb begin
    next_row  = (32'(pixel_y) + 32'd1 >= V_TOTAL) ? 10'd0 : pixel_y + 10'd1;
    swap_x    = HEX_START_X + 32'(slot_q) * HEX_PIXELS_PER_WORD - 32'd1;
    swap      = active_q && (32'(pixel_x) == swap_x);
    row0_trig = (32'(pixel_x) == H_VISIBLE) && (32'(next_row) < HexRows) && (state_q == StIdle);
    line_trig = pending_q && (state_q == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= StIdle;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      word_value  <= '0;
      next_buf_q  <= '0;
      fetch_miss  <= 1'b0;
      slot_q      <= '0;
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      fetch_miss <= 1'b0;
      pending_q  <= 1'b0;
      if (swap) begin
        case (state_q)
          StReady: word_value <= next_buf_q;
          StReq: begin
            if (mem_rd_ack) begin
              word_value <= mem_rd_data;
            end else begin
              word_value <= '0;
              fetch_miss <= 1'b1;
            end
          end
          default: begin
            word_value <= '0;
            fetch_miss <= 1'b1;
          end
        endcase
        // Any outstanding request is abandoned here and never retried
        state_q    <= StIdle;
        mem_rd_req <= 1'b0;
        if (32'(slot_q) < HEX_WORDS_PER_LINE - 1) begin
          slot_q    <= slot_q + SlotW'(1);
          pending_q <= 1'b1;
        end else begin
          active_q <= 1'b0;
        end
      end else if (row0_trig) begin
        state_q     <= StReq;
        mem_rd_req  <= 1'b1;
        mem_rd_addr <= word_addr(next_row, '0);
        slot_q      <= '0;
        active_q    <= 1'b1;
      end else if (line_trig) begin
        state_q     <= StReq;
        mem_rd_req  <= 1'b1;
        mem_rd_addr <= word_addr(pixel_y, slot_q);
      end else if ((state_q == StReq) && mem_rd_ack) begin
        state_q    <= StReady;
        mem_rd_req <= 1'b0;
        next_buf_q <= mem_rd_data;
      end
    end
  end

`ifdef HEX_FETCH_MISS_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetN) begin
      miss_count <= '0;
    end else if (fetch_miss && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule
